// File: rtl/dbg_host_pkg.sv
// Shared constants for the host-side debug command initiator: host opcodes,
// status bytes returned to the host, harness command codes and FSM states.
package dbg_host_pkg;

    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_STEPI = 8'h03;
    localparam logic [7:0] OP_STEPC = 8'h04;
    localparam logic [7:0] OP_DUMP  = 8'h05;

    localparam logic [7:0] RSP_LOAD_OK = 8'hA5;
    localparam logic [7:0] RSP_DONE    = 8'h00;
    localparam logic [7:0] RSP_EXIT    = 8'h01;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
    localparam logic [7:0] RSP_BAD_OP  = 8'hE1;
    localparam logic [7:0] RSP_BAD_LEN = 8'hE2;

    localparam logic [3:0] CMD_IDLE  = 4'd0;
    localparam logic [3:0] CMD_RUN   = 4'd1;
    localparam logic [3:0] CMD_STEPI = 4'd2;
    localparam logic [3:0] CMD_STEPC = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DUMP
    } state_e;

endpackage

// File: rtl/dbg_host_dump_ser.sv
// Serializes the 32x32 register file as 128 bytes, register 0 first, MSB byte first.
// Latency: first byte valid the cycle after start; one byte per cycle when tx_rdy is high.
// Backpressure: byte_vld/byte_dat hold until tx_rdy; done pulses on the final handshake.
module dbg_host_dump_ser (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0][31:0] reg_dump,
    input  logic              tx_rdy,
    output logic              byte_vld,
    output logic [7:0]        byte_dat,
    output logic              done
);

    logic       active_q, active_d;
    logic [4:0] reg_idx_q, reg_idx_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic       fire;
    logic [31:0] word;

    assign fire     = active_q && tx_rdy;
    assign done     = fire && (reg_idx_q == 5'd31) && (byte_idx_q == 2'd3);
    assign byte_vld = active_q;
    assign word     = reg_dump[reg_idx_q];

    always_comb begin
        byte_dat = word[31:24];
        case (byte_idx_q)
            2'd0: byte_dat = word[31:24];
            2'd1: byte_dat = word[23:16];
            2'd2: byte_dat = word[15:8];
            2'd3: byte_dat = word[7:0];
            default: byte_dat = word[31:24];
        endcase
    end

    always_comb begin
        active_d   = active_q;
        reg_idx_d  = reg_idx_q;
        byte_idx_d = byte_idx_q;
        if (start) begin
            active_d   = 1'b1;
            reg_idx_d  = 5'd0;
            byte_idx_d = 2'd0;
        end else if (fire) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                reg_idx_d = reg_idx_q + 5'd1;
            end
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q   <= 1'b0;
            reg_idx_q  <= 5'd0;
            byte_idx_q <= 2'd0;
        end else begin
            active_q   <= active_d;
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/dbg_host_ctrl.sv
// Host byte-stream command initiator for debug_harness: ROM load, RUN/STEPI/STEPC, register dump.
// Latency: opcode accept -> debug_cmd next cycle; payload accept -> ROM write next cycle.
// Backpressure: rx_ready only in IDLE/LEN/LOAD; tx held until tx_ready. DBG_HOST_AUTO_DUMP_EN appends a dump to command status.
module dbg_host_ctrl
    import dbg_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int ROM_BYTES      = 516
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [3:0]        debug_cmd,
    output logic [7:0]        code_rom_data_out,
    output logic [11:0]       code_rom_addr_out,
    output logic              program_rom_mode,
    input  logic              command_complete,
    input  logic              exit_signal,
    input  logic [31:0][31:0] reg_dump
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [12:0]     ROM_MAX  = 13'(ROM_BYTES);
`ifdef DBG_HOST_AUTO_DUMP_EN
    localparam bit AUTO_DUMP = 1'b1;
`else
    localparam bit AUTO_DUMP = 1'b0;
`endif

    state_e        state_q, state_d;
    logic          rst_done_q;
    logic [3:0]    len_hi_q, len_hi_d;
    logic [11:0]   len_q, len_d;
    logic [11:0]   idx_q, idx_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    resp_q, resp_d;
    logic          dump_after_q, dump_after_d;
    logic          rom_we_q, rom_we_d;
    logic [11:0]   rom_addr_q, rom_addr_d;
    logic [7:0]    rom_data_q, rom_data_d;

    logic          rx_fire;
    logic [11:0]   len_n;
    logic          dump_start;
    logic          ser_vld, ser_done;
    logic [7:0]    ser_dat;

    assign rx_ready = rst_done_q && (state_q == S_IDLE || state_q == S_LEN_HI ||
                                     state_q == S_LEN_LO || state_q == S_LOAD);
    assign rx_fire  = rx_valid && rx_ready;
    assign len_n    = {len_hi_q, rx_data};

    assign tx_valid  = (state_q == S_RESP) || (state_q == S_DUMP && ser_vld);
    assign tx_data   = (state_q == S_RESP) ? resp_q :
                       (state_q == S_DUMP) ? ser_dat : 8'h00;
    assign debug_cmd = (state_q == S_ISSUE) ? cmd_q : CMD_IDLE;

    assign program_rom_mode  = rom_we_q;
    assign code_rom_addr_out = rom_addr_q;
    assign code_rom_data_out = rom_data_q;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        tmo_d        = tmo_q;
        resp_d       = resp_q;
        dump_after_d = dump_after_q;
        rom_we_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        dump_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                dump_after_d = 1'b0;
                if (rx_fire) begin
                    case (rx_data)
                        OP_LOAD:  state_d = S_LEN_HI;
                        OP_RUN:   begin cmd_d = CMD_RUN;   state_d = S_ISSUE; end
                        OP_STEPI: begin cmd_d = CMD_STEPI; state_d = S_ISSUE; end
                        OP_STEPC: begin cmd_d = CMD_STEPC; state_d = S_ISSUE; end
                        OP_DUMP:  begin dump_start = 1'b1; state_d = S_DUMP; end
                        default:  begin resp_d = RSP_BAD_OP; state_d = S_RESP; end
                    endcase
                end
            end
            S_LEN_HI: begin
                if (rx_fire) begin
                    len_hi_d = rx_data[3:0];
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_fire) begin
                    len_d = len_n;
                    idx_d = 12'd0;
                    if (len_n == 12'd0) begin
                        resp_d  = RSP_LOAD_OK;
                        state_d = S_RESP;
                    end else if ({1'b0, len_n} > ROM_MAX) begin
                        resp_d  = RSP_BAD_LEN;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (rx_fire) begin
                    rom_we_d   = 1'b1;
                    rom_addr_d = idx_q;
                    rom_data_d = rx_data;
                    idx_d      = idx_q + 12'd1;
                    if (idx_q == len_q - 12'd1) begin
                        resp_d  = RSP_LOAD_OK;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over a timeout landing on the same cycle.
                if (command_complete) begin
                    resp_d       = exit_signal ? RSP_EXIT : RSP_DONE;
                    dump_after_d = 1'b1;
                    state_d      = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    resp_d       = RSP_TIMEOUT;
                    dump_after_d = 1'b0;
                    state_d      = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    if (AUTO_DUMP && dump_after_q) begin
                        dump_start = 1'b1;
                        state_d    = S_DUMP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DUMP: begin
                if (ser_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rst_done_q   <= 1'b0;
            len_hi_q     <= 4'd0;
            len_q        <= 12'd0;
            idx_q        <= 12'd0;
            cmd_q        <= CMD_IDLE;
            tmo_q        <= '0;
            resp_q       <= 8'h00;
            dump_after_q <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= 12'd0;
            rom_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            rst_done_q   <= 1'b1;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            tmo_q        <= tmo_d;
            resp_q       <= resp_d;
            dump_after_q <= dump_after_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
        end
    end

    dbg_host_dump_ser u_dump_ser (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (dump_start),
        .reg_dump (reg_dump),
        .tx_rdy   (tx_ready),
        .byte_vld (ser_vld),
        .byte_dat (ser_dat),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_dbg_host_ctrl.sv
// Directed bench for dbg_host_ctrl; tx bytes and ROM writes are checked against scoreboard queues.
module tb_dbg_host_ctrl;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b1;
    logic [3:0]        debug_cmd;
    logic [7:0]        code_rom_data_out;
    logic [11:0]       code_rom_addr_out;
    logic              program_rom_mode;
    logic              command_complete;
    logic              exit_signal;
    logic [31:0][31:0] reg_dump;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0]  exp_tx[$];
    logic [19:0] exp_wr[$];
    bit          rdy_random = 1'b0;
    logic        stall_q = 1'b0;
    logic [7:0]  hold_dat = 8'h00;

    always #5 clk = ~clk;

    dbg_host_ctrl #(.TIMEOUT_CYCLES(16), .ROM_BYTES(516)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .debug_cmd         (debug_cmd),
        .code_rom_data_out (code_rom_data_out),
        .code_rom_addr_out (code_rom_addr_out),
        .program_rom_mode  (program_rom_mode),
        .command_complete  (command_complete),
        .exit_signal       (exit_signal),
        .reg_dump          (reg_dump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("rx_accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_tx.size() + exp_wr.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++)
                exp_tx.push_back(reg_dump[r][31-8*b -: 8]);
    endtask

    task automatic push_cmd_status(input logic [7:0] st);
        exp_tx.push_back(st);
`ifdef DBG_HOST_AUTO_DUMP_EN
        push_dump();
`endif
    endtask

    // tx_ready driver: held high, or randomly toggled while a dump drains
    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor and tx hold-stability check
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (stall_q) begin
                    chk("tx_hold_vld", 32'(tx_valid), 32'd1);
                    chk("tx_hold_dat", 32'(tx_data), 32'(hold_dat));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        checks++; failures++;
                        $error("FAIL tx_unexpected observed=%0h expected=none", tx_data);
                    end else begin
                        chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    end
                end
                if (program_rom_mode) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $error("FAIL rom_unexpected observed=%0h:%0h expected=none",
                               code_rom_addr_out, code_rom_data_out);
                    end else begin
                        chk("rom_write", {12'd0, code_rom_addr_out, code_rom_data_out},
                            {12'd0, exp_wr.pop_front()});
                    end
                end
                stall_q  = tx_valid && !tx_ready;
                hold_dat = tx_data;
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    initial begin
        int k;
        int first, last, cnt;
        reset_n          = 1'b0;
        rx_valid         = 1'b0;
        rx_data          = 8'h00;
        command_complete = 1'b0;
        exit_signal      = 1'b0;
        for (int r = 0; r < 32; r++)
            reg_dump[r] = {8'(r), 8'(r + 8'h40), 8'(8'h80 - r), 8'(r ^ 8'h5A)};
        reg_dump[0]  = 32'h11223344;
        reg_dump[31] = 32'hCAFEF00D;

        // Reset values
        #12;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_debug_cmd", 32'(debug_cmd), 32'd0);
        chk("rst_rom_mode", 32'(program_rom_mode), 32'd0);
        chk("rst_rom_addr", 32'(code_rom_addr_out), 32'd0);
        chk("rst_rom_data", 32'(code_rom_data_out), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        // LOAD of four bytes
        exp_wr.push_back({12'd0, 8'hDE});
        exp_wr.push_back({12'd1, 8'hAD});
        exp_wr.push_back({12'd2, 8'hBE});
        exp_wr.push_back({12'd3, 8'hEF});
        exp_tx.push_back(8'hA5);
        send(8'h01); send(8'h00); send(8'h04);
        send(8'hDE);
        chk("rom_we_latency", 32'(program_rom_mode), 32'd1);
        chk("rom_addr_first", 32'(code_rom_addr_out), 32'd0);
        send(8'hAD); send(8'hBE); send(8'hEF);
        wait_drain("load4", 100);
        chk("rom_addr_hold", 32'(code_rom_addr_out), 32'd3);
        chk("rom_data_hold", 32'(code_rom_data_out), 32'hEF);

        // Zero-length LOAD, oversize LOADs
        exp_tx.push_back(8'hA5);
        send(8'h01); send(8'h00); send(8'h00);
        wait_drain("load0", 50);
        exp_tx.push_back(8'hE2);
        send(8'h01); send(8'h02); send(8'h05);
        wait_drain("load517", 50);
        chk("rx_ready_after_e2", 32'(rx_ready), 32'd1);
        exp_tx.push_back(8'hE2);
        send(8'h01); send(8'h0F); send(8'hFF);
        wait_drain("load_fff", 50);

        // Unknown opcode
        exp_tx.push_back(8'hE1);
        send(8'h7F);
        wait_drain("bad_op", 50);

        // STEPI normal completion
        push_cmd_status(8'h00);
        send(8'h03);
        chk("stepi_cmd", 32'(debug_cmd), 32'd2);
        @(posedge clk); #1;
        chk("stepi_cmd_pulse", 32'(debug_cmd), 32'd0);
        chk("wait_no_rx", 32'(rx_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1 command_complete = 1'b1;
        @(posedge clk); #1;
        command_complete = 1'b0;
        chk("cc_to_tx", 32'(tx_valid), 32'd1);
        wait_drain("stepi", 400);

        // STEPI with exit flag
        push_cmd_status(8'h01);
        send(8'h03);
        chk("stepi2_cmd", 32'(debug_cmd), 32'd2);
        repeat (5) @(posedge clk);
        #1 command_complete = 1'b1; exit_signal = 1'b1;
        @(posedge clk); #1;
        command_complete = 1'b0; exit_signal = 1'b0;
        wait_drain("stepi_exit", 400);

        // RUN with timeout
        exp_tx.push_back(8'hEE);
        send(8'h02);
        chk("run_cmd", 32'(debug_cmd), 32'd1);
        k = 0;
        while (!tx_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'd17);
        wait_drain("timeout", 50);
        repeat (5) @(posedge clk);
        #1;
        chk("no_dump_after_tmo", 32'(tx_valid), 32'd0);

        // DUMP with toggling tx_ready
        push_dump();
        rdy_random = 1'b1;
        send(8'h05);
        wait_drain("dump_stall", 2000);
        rdy_random = 1'b0;
        @(posedge clk); #1;

        // DUMP back to back
        push_dump();
        send(8'h05);
        first = -1; last = -1; cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        chk("dump_count", 32'(cnt), 32'd128);
        chk("dump_contig", 32'(last - first), 32'd127);
        wait_drain("dump_b2b", 50);

        // Reset in the middle of a LOAD
        exp_wr.push_back({12'd0, 8'h11});
        exp_wr.push_back({12'd1, 8'h22});
        send(8'h01); send(8'h00); send(8'h04);
        send(8'h11); send(8'h22);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_writes", 32'(exp_wr.size()), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_rom_mode", 32'(program_rom_mode), 32'd0);
        chk("mid_rst_rom_addr", 32'(code_rom_addr_out), 32'd0);
        chk("mid_rst_rom_data", 32'(code_rom_data_out), 32'd0);
        chk("mid_rst_cmd", 32'(debug_cmd), 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_after_rst2", 32'(rx_ready), 32'd1);

        // STEPC after reset
        push_cmd_status(8'h00);
        send(8'h04);
        chk("stepc_cmd", 32'(debug_cmd), 32'd3);
        repeat (3) @(posedge clk);
        #1 command_complete = 1'b1;
        @(posedge clk); #1;
        command_complete = 1'b0;
        wait_drain("stepc", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
